// File: rtl/edge_toggle_bank.sv
// Multi-channel debounced edge detector with per-channel pulse, toggle and event count.
// Optional saturating event counters are enabled by defining EDGE_TOGGLE_BANK_EVCNT_EN.
module edge_toggle_bank #(
  parameter int CH         = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     btn_in,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     lvl,
  output logic [CH-1:0]     pulse,
  output logic [CH-1:0]     tgl,
  output logic [8*CH-1:0]   evcnt
);

  localparam int            CW      = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [CH-1:0] sync1_q, sync2_q;
  logic [CH-1:0] lvl_q, lvl_d;
  logic [CH-1:0] ev_q, ev_d;
  logic [CH-1:0] pulse_q;
  logic [CH-1:0] tgl_q, tgl_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // ev_q marks "lvl changed last edge and the mode wanted it"; it becomes pulse
  // one edge later, so mode is captured exactly at the lvl change edge.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    lvl_d = lvl_q;
    ev_d  = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = sync2_q[i];
          ev_d[i]  = sync2_q[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      tgl_d[i] = clr[i] ? 1'b0 : (tgl_q[i] ^ ev_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      ev_q    <= '0;
      pulse_q <= '0;
      tgl_q   <= '0;
      // NOTE: the counter array is small state that must abort on reset, so each entry is cleared.
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values, like real flops.
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      ev_q    <= ev_d;
      pulse_q <= ev_q;
      tgl_q   <= tgl_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign lvl   = lvl_q;
  assign pulse = pulse_q;
  assign tgl   = tgl_q;

`ifdef EDGE_TOGGLE_BANK_EVCNT_EN
  logic [7:0] evc_q [CH];
  logic [7:0] evc_d [CH];

  // Counts follow pulse (ev_q is what pulse takes on this edge); clear wins, 255 sticks.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      evc_d[i] = evc_q[i];
      if (clr[i]) begin
        evc_d[i] = 8'd0;
      end else if (ev_q[i] && (evc_q[i] != 8'hFF)) begin
        evc_d[i] = evc_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) evc_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < CH; i++) evc_q[i] <= evc_d[i];
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_evc
    assign evcnt[8*g +: 8] = evc_q[g];
  end
`else
  assign evcnt = '0;
`endif

endmodule

// File: tb/tb_edge_toggle_bank.sv
// Scoreboard bench for edge_toggle_bank: a behavioural model queues the expected
// outputs every edge and a negedge monitor pops and compares them.
module tb_edge_toggle_bank;

  localparam int CH  = 4;
  localparam int DEB = 4;

`ifdef EDGE_TOGGLE_BANK_EVCNT_EN
  localparam bit EVC_ON = 1'b1;
`else
  localparam bit EVC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     btn_in = '0;
  logic [2*CH-1:0]   mode = '0;
  logic [CH-1:0]     clr = '0;
  logic [CH-1:0]     lvl, pulse, tgl;
  logic [8*CH-1:0]   evcnt;

  always #5 clk = ~clk;

  edge_toggle_bank #(.CH(CH), .DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_in),
    .mode   (mode),
    .clr    (clr),
    .lvl    (lvl),
    .pulse  (pulse),
    .tgl    (tgl),
    .evcnt  (evcnt)
  );

  typedef struct {
    logic [CH-1:0]   lvl;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   tgl;
    logic [8*CH-1:0] evc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pcount[CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference model: debounce as "DEB consecutive disagreeing samples seen two
  // edges late", events delayed one extra edge to become pulses.
  bit m_hist[CH][$];
  bit m_lvl[CH], m_ev[CH], m_pulse[CH], m_tgl[CH];
  int m_run[CH], m_cnt[CH];
  bit seen, nxt_pulse;
  exp_t snap;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_hist[i].delete();
        m_lvl[i] = 0; m_ev[i] = 0; m_pulse[i] = 0; m_tgl[i] = 0;
        m_run[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        seen      = (m_hist[i].size() == 2) ? m_hist[i][0] : 1'b0;
        nxt_pulse = m_ev[i];
        m_ev[i]   = 1'b0;
        if (seen != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = seen;
            m_run[i] = 0;
            m_ev[i]  = seen ? mode[2*i] : mode[2*i+1];
          end
        end else begin
          m_run[i] = 0;
        end
        m_pulse[i] = nxt_pulse;
        if (clr[i]) begin
          m_tgl[i] = 1'b0;
          m_cnt[i] = 0;
        end else if (nxt_pulse) begin
          m_tgl[i] = ~m_tgl[i];
          if (m_cnt[i] < 255) m_cnt[i]++;
        end
        m_hist[i].push_back(btn_in[i]);
        if (m_hist[i].size() > 2) void'(m_hist[i].pop_front());
      end
    end
    for (int i = 0; i < CH; i++) begin
      snap.lvl[i]         = m_lvl[i];
      snap.pulse[i]       = m_pulse[i];
      snap.tgl[i]         = m_tgl[i];
      snap.evc[8*i +: 8]  = EVC_ON ? 8'(m_cnt[i]) : 8'd0;
    end
    exp_q.push_back(snap);
  end

  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_lvl",   lvl,   '0);
      check("reset_pulse", pulse, '0);
      check("reset_tgl",   tgl,   '0);
      check("reset_evcnt", evcnt, '0);
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_underflow: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_lvl",   lvl,   e.lvl);
      check("sb_pulse", pulse, e.pulse);
      check("sb_tgl",   tgl,   e.tgl);
      check("sb_evcnt", evcnt, e.evc);
      for (int i = 0; i < CH; i++) if (pulse[i]) pcount[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges after the first edge that samples the new input until pulse[ch] is seen.
  task automatic measure_latency(input int ch, output int n);
    bit found;
    found = 0;
    n = -1;
    while (!found && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pulse[ch]) found = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int lat;

  initial begin
    for (int i = 0; i < CH; i++) pcount[i] = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Falling-only channel 0: rise is silent, fall pulses DEB+2 edges later.
    mode[1:0] = 2'b10;
    btn_in[0] = 1'b1;
    tick(20);
    @(negedge clk);
    check("r029_lvl_rise", lvl[0], 1'b1);
    check("r029_tgl_pre",  tgl[0], 1'b0);
    tick(1);
    btn_in[0] = 1'b0;
    measure_latency(0, lat);
    check("r029_fall_latency", lat, DEB + 2);
    @(negedge clk);
    check("r029_tgl_post",  tgl[0],   1'b1);
    check("r029_pulse_one", pulse[0], 1'b0);
    tick(1);

    // Bouncing input never settles long enough.
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    mode[1:0] = 2'b11;
    pcount[0] = 0;
    for (int k = 0; k < 20; k++) begin
      btn_in[0] = ~btn_in[0];
      tick(2);
    end
    tick(4);
    @(negedge clk);
    check("r030_lvl",    lvl[0],    1'b0);
    check("r030_tgl",    tgl[0],    1'b0);
    check("r030_pulses", pcount[0], 0);
    tick(1);

    // Both-edge channel 2: press and release give two pulses.
    mode[5:4] = 2'b11;
    pcount[2] = 0;
    btn_in[2] = 1'b1;
    tick(10);
    btn_in[2] = 1'b0;
    tick(10);
    @(negedge clk);
    check("r031_pulses", pcount[2],     2);
    check("r031_tgl",    tgl[2],        1'b0);
    check("r031_evcnt",  evcnt[23:16],  EVC_ON ? 8'd2 : 8'd0);
    tick(1);

    // Clear coincident with the pulse edge on channel 1.
    mode[3:2] = 2'b01;
    btn_in[1] = 1'b1;
    tick(DEB + 2);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    @(negedge clk);
    check("r032_pulse", pulse[1],     1'b1);
    check("r032_tgl",   tgl[1],       1'b0);
    check("r032_evcnt", evcnt[15:8],  8'd0);
    tick(DEB + 2);
    btn_in[1] = 1'b0;
    tick(DEB + 4);

    // Reset mid-debounce on channel 3, then the held input re-debounces.
    btn_in[0] = 1'b1;
    tick(DEB + 5);
    mode[7:6] = 2'b01;
    btn_in[3] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("r033_lvl_async",   lvl,   '0);
    check("r033_tgl_async",   tgl,   '0);
    check("r033_pulse_async", pulse, '0);
    tick(2);
    rst_n = 1'b1;
    measure_latency(3, lat);
    check("r033_latency", lat, DEB + 2);
    btn_in = '0;
    tick(DEB + 6);

    // Randomized traffic with random modes, clears and one reset.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(7) == 0) btn_in[i] = ~btn_in[i];
        clr[i] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(31) == 0) mode = 8'($urandom);
      if (cyc == 400) rst_n = 1'b0;
      if (cyc == 402) rst_n = 1'b1;
      tick(1);
    end
    clr    = '0;
    btn_in = '0;
    tick(DEB + 6);

    // 300 rising events on channel 0 saturate the count.
    mode[1:0] = 2'b01;
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    pcount[0] = 0;
    for (int k = 0; k < 300; k++) begin
      btn_in[0] = 1'b1;
      tick(DEB + 3);
      btn_in[0] = 1'b0;
      tick(DEB + 3);
    end
    tick(DEB + 4);
    @(negedge clk);
    check("r034_pulses", pcount[0],   300);
    check("r034_evcnt",  evcnt[7:0],  EVC_ON ? 8'd255 : 8'd0);
    check("r034_tgl",    tgl[0],      1'b0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_toggle_bank.md
EDGE_TOGGLE_BANK -- requirements
Module: edge_toggle_bank

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 16: debounce length in clk cycles, legal range 1..65535.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port btn_in  input  CH: raw asynchronous inputs (buttons/switches), one bit per channel.
REQ-006 Port mode  input  2*CH: per-channel edge select, bits [2i+1:2i]; 00 none, 01 rising, 10 falling, 11 both.
REQ-007 Port clr  input  CH: synchronous per-channel toggle clear.
REQ-008 Port lvl  output  CH: debounced level per channel.
REQ-009 Port pulse  output  CH: one-cycle strobe per selected debounced edge.
REQ-010 Port tgl  output  CH: toggle state, inverts on every pulse.
REQ-011 Port evcnt  output  8*CH: per-channel event count, bits [8i+7:8i].

Function
REQ-012 Each channel SHALL pass btn_in through a 2-flop synchroniser before any other logic.
REQ-013 Each channel SHALL hold a debounce counter of width ceil(log2(DEB_CYCLES))+1 and a stable-level register driving lvl.
REQ-014 Synchronised input equal to lvl: counter SHALL clear to 0 on that edge.
REQ-015 Synchronised input different from lvl and counter < DEB_CYCLES-1: counter SHALL increment by 1.
REQ-016 Synchronised input different from lvl and counter == DEB_CYCLES-1: lvl SHALL take the new value and the counter SHALL clear, on the same edge.
REQ-017 Any disagreement shorter than DEB_CYCLES consecutive cycles (bounce/glitch) SHALL leave lvl unchanged.
REQ-018 pulse[i] SHALL be registered and high for exactly one cycle, on the cycle after lvl[i] changes, when the change matches mode[i] (rise 0->1, fall 1->0).
REQ-019 mode SHALL be sampled at the lvl change edge; a mode change between edges SHALL NOT generate or suppress pulses retroactively.
REQ-020 Latency: a level held on btn_in from rising edge E0 SHALL produce pulse high after edge E0+DEB_CYCLES+2 (DEB_CYCLES=1: E0+3).
REQ-021 tgl[i] SHALL invert on the same edge pulse[i] asserts.
REQ-022 clr[i] high SHALL force tgl[i] to 0 on that edge; clr and pulse on the same edge: tgl[i]=0 (clr wins), pulse[i] still asserts.
REQ-023 Channels SHALL be fully independent; simultaneous events on any subset SHALL all be processed in the same cycle.

Reset
REQ-024 rst_n low SHALL asynchronously set synchronisers, lvl, counters, pulse, tgl and evcnt to 0.
REQ-025 Reset asserted mid-debounce or with pulse high SHALL abort the event; no pulse SHALL follow reset release for it.
REQ-026 An input at 1 when rst_n releases SHALL be treated as a new rising edge and debounced normally.

Configuration
REQ-027 Macro EDGE_TOGGLE_BANK_EVCNT_EN defined: evcnt[i] SHALL increment on each pulse[i], saturate at 255, clear to 0 on clr[i] (clr wins over increment).
REQ-028 Macro EDGE_TOGGLE_BANK_EVCNT_EN undefined: evcnt SHALL be tied to 0 and no counter logic SHALL be synthesised; all other behaviour unchanged.

Verification
REQ-029 DEB_CYCLES=4, mode[1:0]=10, btn_in[0] 1 held 20 cycles then 0 held -> lvl[0] rises, no pulse on rise; pulse[0] one cycle 6 edges after fall sampled; tgl[0] 0->1.
REQ-030 DEB_CYCLES=4, btn_in[0] toggled every 2 cycles for 40 cycles -> lvl[0], pulse[0], tgl[0] stay 0.
REQ-031 mode=11 on ch2, clean press and release -> two pulses, tgl[2] returns to 0; evcnt[23:16]=2 with macro, 0 without.
REQ-032 clr[1] asserted on the pulse[1] cycle -> pulse[1]=1, tgl[1]=0 next; evcnt[15:8]=0.
REQ-033 rst_n pulsed low at debounce counter=2 with input held high -> all outputs 0 at once; after release pulse appears DEB_CYCLES+2 edges later (rising, mode=01).
REQ-034 300 rising events on ch0 with macro -> evcnt[7:0] saturates at 255, tgl[0] ends 0.
